vga_line_fifo: RTL and testbench
================================

// Module: vga_line_fifo
// PURPOSE
//  Pixel-clock FIFO directly upstream of the vga timing generator. It buffers 24-bit RGB pixels
//  from a memory/DMA producer and serves one pixel per fetch_next on red/green/blue_byte.
//  It supports y-doublescan: line_repeat rewinds the read side so the previous scan line is read again.
//  Storage is one simple-dual-port RAM with a registered read (maps to one BRAM).
// PARAMETERS
//  C_addr_bits  11   log2 of RAM depth; depth = 2**C_addr_bits words of 24 bit
//  C_line_len   640  pixels per visible line; must be <= 2**C_addr_bits / 2
// PORTS
//  clk_pixel    in   1    pixel clock; the only clock
//  reset        in   1    synchronous, active-high
//  flush        in   1    1-cycle pulse at frame start: empties the FIFO
//  in_valid     in   1    producer word valid
//  in_ready     out  1    FIFO can accept; a word transfers when in_valid & in_ready
//  in_data      in   24   {red[23:16], green[15:8], blue[7:0]}
//  fetch_next   in   1    consume one pixel (from vga)
//  line_repeat  in   1    level; rising edge rewinds to start of the current line (from vga)
//  red_byte     out  8    pixel red
//  green_byte   out  8    pixel green
//  blue_byte    out  8    pixel blue
//  level        out  C_addr_bits+1  words held, including words kept for a repeat (wr_ptr - line_start)
//  underflow    out  1    1-cycle pulse: fetch_next while no unread word
// BEHAVIOUR
//  - Pointers: wr_ptr, rd_ptr and line_start, each C_addr_bits+1 bits, mod 2**(C_addr_bits+1).
//  - RAM address = low C_addr_bits of the pointer.
//  - avail = wr_ptr - rd_ptr (unread words).
//  - level = wr_ptr - line_start; full when level == 2**C_addr_bits.
//  - in_ready = !full; it is combinational from registered pointers only, not from in_valid.
//  - Write: on in_valid & in_ready, mem[wr_ptr] <= in_data and wr_ptr++.
//  - Read, latency 1: the cycle with fetch_next and avail != 0 loads the RGB registers from
//    mem[rd_ptr], rd_ptr++, pix_cnt++. The pixel is visible on *_byte in the next cycle.
//  - fetch_next with avail == 0: RGB registers load 0; rd_ptr and pix_cnt hold; underflow pulses.
//  - Without fetch_next, the RGB registers hold their value.
//  - pix_cnt (12 bit) counts pixels of the current line.
//    - When pix_cnt == 0 and a fetch succeeds, line_start <= rd_ptr before the increment.
//      This frees the previous line.
//    - When pix_cnt reaches C_line_len it wraps to 0.
//  - line_repeat is edge-detected with register lr_q. When line_repeat & !lr_q:
//    rd_ptr <= line_start and pix_cnt <= 0. Entries from line_start onward are never overwritten,
//    so the repeat reads identical data.
//  - Rewind and fetch_next in the same cycle is a protocol violation. Rewind wins; the fetch is
//    treated as underflow (outputs 0, pulse).
//  - Write concurrent with rewind or fetch is always allowed. Full is evaluated on pre-edge pointers.
//  - Priority, highest first: reset > flush > rewind > fetch/write.
//  - flush: wr_ptr = rd_ptr = line_start = 0, pix_cnt = 0, RGB registers = 0. Any write in the
//    same cycle is dropped. lr_q still samples line_repeat.
//  - Reset values: all pointers 0, pix_cnt 0, lr_q 0, red/green/blue_byte 0, underflow 0,
//    in_ready 1, level 0.
//  - Reset mid-line discards all content. The first fetch after reset with no data gives
//    underflow and 0 output.
// CONFIGURATION
//  VGA_LINE_FIFO_UNDERFLOW_CNT_EN defined:
//    - adds output underflow_count[15:0], incremented on each underflow pulse;
//    - saturates at 16'hFFFF;
//    - cleared by reset only (not by flush).
//  Not defined: the port and counter are absent; all other behaviour is identical.
// TESTING
//  1. Reset, then write 4 words 0x010203..0x0A0B0C, then fetch_next 4 cycles ->
//     *_byte show 01/02/03 .. 0A/0B/0C on cycles t+1..t+4; no underflow.
//  2. C_line_len=8: fill 16 words, read 8, raise line_repeat, read 8 ->
//     the second pass equals words 0..7; the next 8 fetches give words 8..15; level 16 -> 8 after
//     the first fetch of words 8..15.
//  3. C_addr_bits=4: write continuously, no fetch -> in_ready falls after 16 words; level=16.
//     One full line read without repeat, then one fetch -> space frees and in_ready rises.
//  4. Empty FIFO, fetch_next one cycle -> underflow pulses once; *_byte = 0; rd_ptr unchanged;
//     with the macro, underflow_count = 1.
//  5. Mid-line flush while in_valid is high -> level=0 next cycle, the write is dropped,
//     *_byte = 0; the next write/fetch returns the new word.
//  6. Random producer stalls, 100 lines of 640 px with alternating line_repeat ->
//     the output stream matches the scoreboard with every line duplicated; zero underflow.

Source files
------------

// File: rtl/vga_line_fifo_if.sv
// vga_line_fifo_if
//   Bundles the producer handshake and the vga-side pixel port of vga_line_fifo.
//   master : drives flush, in_valid, in_data, fetch_next, line_repeat
//   slave  : the FIFO; drives in_ready, red/green/blue_byte, level, underflow
//   Optional macro VGA_LINE_FIFO_UNDERFLOW_CNT_EN adds underflow_count[15:0].
interface vga_line_fifo_if #(
   parameter int C_addr_bits = 11
);
   logic                 flush;
   logic                 in_valid;
   logic                 in_ready;
   logic [23:0]          in_data;
   logic                 fetch_next;
   logic                 line_repeat;
   logic [7:0]           red_byte;
   logic [7:0]           green_byte;
   logic [7:0]           blue_byte;
   logic [C_addr_bits:0] level;
   logic                 underflow;
`ifdef VGA_LINE_FIFO_UNDERFLOW_CNT_EN
   logic [15:0]          underflow_count;

   modport master (
      output flush, in_valid, in_data, fetch_next, line_repeat,
      input  in_ready, red_byte, green_byte, blue_byte, level, underflow, underflow_count
   );
   modport slave (
      input  flush, in_valid, in_data, fetch_next, line_repeat,
      output in_ready, red_byte, green_byte, blue_byte, level, underflow, underflow_count
   );
`else
   modport master (
      output flush, in_valid, in_data, fetch_next, line_repeat,
      input  in_ready, red_byte, green_byte, blue_byte, level, underflow
   );
   modport slave (
      input  flush, in_valid, in_data, fetch_next, line_repeat,
      output in_ready, red_byte, green_byte, blue_byte, level, underflow
   );
`endif
endinterface

// File: rtl/vga_line_fifo.sv
// vga_line_fifo
//   Pixel-clock line FIFO in front of the vga timing generator. Buffers 24-bit
//   RGB words from a producer and hands out one pixel per fetch_next with one
//   cycle of latency. A rising edge on line_repeat rewinds the read pointer to
//   the start of the current line so the line can be scanned twice.
// Ports
//   clk_pixel : pixel clock
//   reset     : synchronous, active-high
//   bus       : vga_line_fifo_if.slave (flush, producer handshake, pixel port,
//               level, underflow)
// Optional feature
//   VGA_LINE_FIFO_UNDERFLOW_CNT_EN : saturating 16-bit underflow counter on
//   bus.underflow_count, cleared only by reset.
module vga_line_fifo #(
   parameter int C_addr_bits = 11,
   parameter int C_line_len  = 640
) (
   input logic          clk_pixel,
   input logic          reset,
   vga_line_fifo_if.slave bus
);
   localparam int DEPTH = 2 ** C_addr_bits;
   typedef logic [C_addr_bits:0] ptr_t;

   logic [23:0] mem [DEPTH];

   ptr_t        wr_ptr_q, wr_ptr_d;
   ptr_t        rd_ptr_q, rd_ptr_d;
   ptr_t        ls_q, ls_d;           // line_start: oldest word still needed
   logic [11:0] pix_cnt_q, pix_cnt_d;
   logic        lr_q;
   logic [23:0] rgb_q;
   logic        uf_q;

   ptr_t        avail, level;
   logic        full, rewind, wr_en, rd_ok, uf;

   assign avail  = wr_ptr_q - rd_ptr_q;
   assign level  = wr_ptr_q - ls_q;
   // Full counts words kept for a repeat, so line_start onward is never overwritten.
   assign full   = (level == ptr_t'(DEPTH));
   assign rewind = bus.line_repeat & ~lr_q;
   assign wr_en  = bus.in_valid & ~full & ~bus.flush & ~reset;
   // A fetch colliding with a rewind is dropped and reported as underflow.
   assign rd_ok  = bus.fetch_next & ~bus.flush & ~rewind & (avail != '0);
   assign uf     = bus.fetch_next & ~bus.flush & (rewind | (avail == '0));

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      ls_d      = ls_q;
      pix_cnt_d = pix_cnt_q;
      if (bus.flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         ls_d      = '0;
         pix_cnt_d = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
         if (rewind) begin
            rd_ptr_d  = ls_q;
            pix_cnt_d = '0;
         end else if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            // First pixel of a new line releases the previous line.
            if (pix_cnt_q == '0) ls_d = rd_ptr_q;
            pix_cnt_d = (pix_cnt_q == 12'(C_line_len - 1)) ? '0 : pix_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         ls_q      <= '0;
         pix_cnt_q <= '0;
         lr_q      <= 1'b0;
         uf_q      <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         ls_q      <= ls_d;
         pix_cnt_q <= pix_cnt_d;
         lr_q      <= bus.line_repeat;
         uf_q      <= uf;
      end
   end

   // Storage: plain write port, no reset, so it maps onto one block RAM.
   always_ff @(posedge clk_pixel) begin
      if (wr_en) mem[wr_ptr_q[C_addr_bits-1:0]] <= bus.in_data;
   end

   // Registered read port doubles as the pixel output register.
   always_ff @(posedge clk_pixel) begin
      if (reset || bus.flush || uf) rgb_q <= '0;
      else if (rd_ok)               rgb_q <= mem[rd_ptr_q[C_addr_bits-1:0]];
   end

`ifdef VGA_LINE_FIFO_UNDERFLOW_CNT_EN
   logic [15:0] ucnt_q;
   always_ff @(posedge clk_pixel) begin
      if (reset)                           ucnt_q <= '0;
      else if (uf && ucnt_q != 16'hFFFF)   ucnt_q <= ucnt_q + 1'b1;
   end
   assign bus.underflow_count = ucnt_q;
`endif

   assign bus.in_ready   = ~full;
   assign bus.level      = level;
   assign bus.red_byte   = rgb_q[23:16];
   assign bus.green_byte = rgb_q[15:8];
   assign bus.blue_byte  = rgb_q[7:0];
   assign bus.underflow  = uf_q;
endmodule

// File: tb/tb_vga_line_fifo.sv
// tb_vga_line_fifo
//   Directed bench for vga_line_fifo with a 16-word RAM and 8-pixel lines.
//   Inputs change right after the falling edge; outputs are sampled at the
//   following falling edge.
module tb_vga_line_fifo;
   localparam int AW = 4;
   localparam int LL = 8;
   localparam int NL = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   vga_line_fifo_if #(.C_addr_bits(AW)) bus ();
   vga_line_fifo #(.C_addr_bits(AW), .C_line_len(LL)) u_dut (
      .clk_pixel(clk),
      .reset    (rst),
      .bus      (bus)
   );

   int n_tot = 0;
   int n_ok  = 0;
   int idx;
   logic [23:0] rgb;
   assign rgb = {bus.red_byte, bus.green_byte, bus.blue_byte};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tot++;
      if (got === exp) n_ok++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   function automatic logic [23:0] wd(input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b, ~b, b ^ 8'hA5};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic push(input logic [23:0] d);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic pop(input string tag, input logic [23:0] exp);
      bus.fetch_next = 1'b1;
      @(negedge clk);
      bus.fetch_next = 1'b0;
      chk(tag, 32'(rgb), 32'(exp));
      chk({tag, "_uf"}, 32'(bus.underflow), 32'd0);
   endtask

   task automatic rewind();
      bus.line_repeat = 1'b1;
      @(negedge clk);
      bus.line_repeat = 1'b0;
   endtask

   initial begin
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
      bus.fetch_next = 1'b0; bus.line_repeat = 1'b0;
      @(negedge clk);
      do_reset();

      // reset state
      chk("rst_rgb",   32'(rgb),          32'd0);
      chk("rst_uf",    32'(bus.underflow), 32'd0);
      chk("rst_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_level", 32'(bus.level),    32'd0);

      // 1: four words, four back-to-back fetches
      push(24'h010203); push(24'h040506); push(24'h070809); push(24'h0A0B0C);
      chk("t1_level", 32'(bus.level), 32'd4);
      pop("t1_p0", 24'h010203); pop("t1_p1", 24'h040506);
      pop("t1_p2", 24'h070809); pop("t1_p3", 24'h0A0B0C);

      // 2: doublescan of line 0, then line 1 frees line 0
      do_reset();
      for (int i = 0; i < 16; i++) push(wd(i));
      chk("t2_level16", 32'(bus.level), 32'd16);
      for (int i = 0; i < 8; i++) pop("t2_a", wd(i));
      rewind();
      for (int i = 0; i < 8; i++) pop("t2_rep", wd(i));
      chk("t2_level_pre", 32'(bus.level), 32'd16);
      pop("t2_b8", wd(8));
      chk("t2_level8", 32'(bus.level), 32'd8);
      for (int i = 9; i < 16; i++) pop("t2_b", wd(i));

      // 3: fill to full, 17th word dropped, one line + one fetch frees space
      do_reset();
      for (int i = 0; i < 17; i++) begin
         if (i == 16) chk("t3_ready_full", 32'(bus.in_ready), 32'd0);
         push(wd(i + 32));
      end
      chk("t3_level", 32'(bus.level), 32'd16);
      for (int i = 0; i < 8; i++) pop("t3_a", wd(i + 32));
      chk("t3_ready_line", 32'(bus.in_ready), 32'd0);
      pop("t3_b", wd(40));
      chk("t3_ready_free", 32'(bus.in_ready), 32'd1);
      chk("t3_level8", 32'(bus.level), 32'd8);

      // 4: underflow on empty clears output and does not move rd_ptr
      do_reset();
      push(24'h123456);
      pop("t4_pre", 24'h123456);
      bus.fetch_next = 1'b1;
      @(negedge clk);
      bus.fetch_next = 1'b0;
      chk("t4_uf", 32'(bus.underflow), 32'd1);
      chk("t4_rgb0", 32'(rgb), 32'd0);
`ifdef VGA_LINE_FIFO_UNDERFLOW_CNT_EN
      chk("t4_ucnt", 32'(bus.underflow_count), 32'd1);
`endif
      @(negedge clk);
      chk("t4_uf_pulse", 32'(bus.underflow), 32'd0);
      push(24'h654321);
      pop("t4_post", 24'h654321);

      // 5: flush mid-line with a write in the same cycle
      do_reset();
      push(24'hAA0001); push(24'hAA0002); push(24'hAA0003);
      pop("t5_pre", 24'hAA0001);
      bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_data = 24'hDEAD00;
      @(negedge clk);
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      chk("t5_level0", 32'(bus.level), 32'd0);
      chk("t5_rgb0", 32'(rgb), 32'd0);
      push(24'h5A5A5A);
      chk("t5_level1", 32'(bus.level), 32'd1);
      pop("t5_new", 24'h5A5A5A);

      // 6: stalled producer, every line scanned twice
      do_reset();
      idx = 0;
      fork
         begin : producer
            int guard = 0;
            logic xfer;
            while (idx < NL * LL && guard < 20000) begin
               @(negedge clk);
               bus.in_valid = ($urandom_range(0, 3) != 0);
               bus.in_data  = wd(idx + 100);
               xfer = bus.in_valid && bus.in_ready;
               @(posedge clk);
               if (xfer) idx++;
               guard++;
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
            chk("t6_prod_done", 32'(idx), 32'(NL * LL));
         end
         begin : consumer
            for (int ln = 0; ln < NL; ln++) begin
               for (int ps = 0; ps < 2; ps++) begin
                  if (ps == 1) rewind();
                  for (int px = 0; px < LL; px++) begin
                     int g = 0;
                     while (idx <= ln * LL + px && g < 200) begin
                        @(negedge clk);
                        g++;
                     end
                     if (g >= 200) chk("t6_wait", 32'(idx), 32'(ln * LL + px + 1));
                     pop("t6_px", wd(ln * LL + px + 100));
                  end
               end
            end
         end
      join

      $display("%0d/%0d checks passed", n_ok, n_tot);
      $finish;
   end
endmodule
